// File: rtl/mul_unit.sv
// mul_unit: iterative 32-bit multiply / multiply-accumulate (radix-2 shift-add).
// Computes result = a*b (+acc) mod 2^32, with early termination as soon as the
// remaining multiplier bits are zero. On completion it raises a one-cycle done
// pulse, which serves as the register-file write enable, and holds
// result/tag_out/flags until the next operation completes.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      request, sampled only in IDLE or DONE
//   accumulate 1 = MLA (add acc), 0 = MUL
//   a, b, acc  multiplicand (Rm), multiplier (Rs), accumulate operand (Rn)
//   tag_in     destination register index
//   busy       high while an operation is running
//   done       one-cycle completion pulse
//   result     product (+acc), held between completions
//   tag_out    captured tag_in, held like result
//   flag_n     result[31], held like result
//   flag_z     result == 0, held like result
module mul_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        accumulate,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] acc,
    input  logic [3:0]  tag_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  tag_out,
    output logic        flag_n,
    output logic        flag_z
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] prod;
    logic [31:0] prod_nxt;
    logic [4:0]  cnt;
    logic [3:0]  tag;
    logic        last;

    // The step that finishes an operation must still fold in its own partial
    // product, so the published result is taken from prod_nxt, not prod.
    always_comb begin
        prod_nxt = mb[0] ? (prod + ma) : prod;
        last     = (mb[31:1] == '0) || (cnt == 5'd31);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ma      <= '0;
            mb      <= '0;
            prod    <= '0;
            cnt     <= '0;
            tag     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            tag_out <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    prod <= prod_nxt;
                    ma   <= ma << 1;
                    mb   <= mb >> 1;
                    cnt  <= cnt + 5'd1;
                    if (last) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= prod_nxt;
                        tag_out <= tag;
                        flag_n  <= prod_nxt[31];
                        flag_z  <= (prod_nxt == '0);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE always
                    // leaves after one cycle, so back-to-back has no gap.
                    done <= 1'b0;
                    if (start) begin
                        ma    <= a;
                        mb    <= b;
                        prod  <= accumulate ? acc : '0;
                        tag   <= tag_in;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        accumulate = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] acc = '0;
    logic [3:0]  tag_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  tag_out;
    logic        flag_n;
    logic        flag_z;

    int checks = 0;
    int passes = 0;

    mul_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .accumulate (accumulate),
        .a          (a),
        .b          (b),
        .acc        (acc),
        .tag_in     (tag_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .tag_out    (tag_out),
        .flag_n     (flag_n),
        .flag_z     (flag_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model (operation level) ----------------
    // Tracks only "cycles left" and the operation's arithmetic answer.
    int          m_left = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    logic [31:0] m_res = '0;
    logic [3:0]  m_tag = '0;
    bit          m_fn = 0;
    bit          m_fz = 0;
    logic [31:0] p_res = '0;
    logic [3:0]  p_tag = '0;

    function automatic int calc_k(input logic [31:0] v);
        int k = 1;
        for (int i = 0; i < 32; i++) if (v[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [31:0] calc_res(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] z, input logic ac);
        logic [63:0] p;
        logic [31:0] lo;
        p  = {32'b0, x} * {32'b0, y};
        lo = p[31:0];
        return lo + (ac ? z : 32'd0);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0; m_busy = 0; m_done = 0;
            m_res = '0; m_tag = '0; m_fn = 0; m_fz = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
                m_res  = p_res;
                m_tag  = p_tag;
                m_fn   = p_res[31];
                m_fz   = (p_res == 0);
            end
        end else begin
            m_done = 0;
            if (start) begin
                p_res  = calc_res(a, b, acc, accumulate);
                p_tag  = tag_in;
                m_left = calc_k(b);
                m_busy = 1;
            end
        end
    end

    // One compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("cycle{busy,done,result,tag,n,z}",
            {24'b0, busy, done, result, tag_out, flag_n, flag_z},
            {24'b0, m_busy, m_done, m_res, m_tag, m_fn, m_fz});
        if (busy && done) chk("busy_done_overlap", 1, 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] xacc,
                            input logic xac, input logic [3:0] xtag);
        a = xa; b = xb; acc = xacc; accumulate = xac; tag_in = xtag; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; acc = $urandom; tag_in = 4'($urandom);
    endtask

    // Returns the number of edges after the start edge at which done appeared.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = -1;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin edges = n; break; end
            if (busy === 1'b1) busy_cycles++;
        end
        if (edges < 0) chk("done_timeout", 0, 1);
    endtask

    int e, bc;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, result, tag_out, flag_n, flag_z}, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // MUL 3*5
        start_op(32'd3, 32'd5, 32'hDEAD, 1'b0, 4'd4);
        wait_done(e, bc);
        chk("mul_latency", e, 3);
        chk("mul_busy_cycles", bc, 3);
        chk("mul_result", result, 15);
        chk("mul_tag", tag_out, 4);
        chk("mul_flags", {flag_n, flag_z}, 2'b00);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);

        // MLA with wrap
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 1'b1, 4'd9);
        wait_done(e, bc);
        chk("mla_latency", e, 32);
        chk("mla_result", result, 3);

        // Hold: 10 idle cycles with random inputs
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom; acc = $urandom; accumulate = 1'($urandom);
            tag_in = 4'($urandom);
        end
        chk("hold_result", {done, result, tag_out, flag_n, flag_z}, {1'b0, 32'd3, 4'd9, 1'b0, 1'b0});

        // Zero multiplier
        start_op(32'h1234, 32'd0, 32'd0, 1'b0, 4'd1);
        wait_done(e, bc);
        chk("zero_latency", e, 1);
        chk("zero_result_z", {result, flag_z}, {32'd0, 1'b1});

        // Negative result
        start_op(32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'd2);
        wait_done(e, bc);
        chk("neg_result_n", {result, flag_n, flag_z}, {32'hFFFF_FFFE, 1'b1, 1'b0});

        // Back-to-back plus ignored start during RUN
        start_op(32'd2, 32'd3, 32'd0, 1'b0, 4'd5);
        wait_done(e, bc);
        chk("b2b_first", result, 6);
        start_op(32'd5, 32'd6, 32'd0, 1'b0, 4'd6);
        chk("b2b_no_gap", {busy, done, result}, {1'b1, 1'b0, 32'd6});
        start_op(32'd100, 32'd100, 32'd0, 1'b0, 4'd7);
        wait_done(e, bc);
        chk("b2b_second", {result, tag_out}, {32'd30, 4'd6});

        // Reset mid-RUN
        @(posedge clk); #1;
        start_op(32'd7, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd3);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_midrun", {busy, done, result, tag_out, flag_n, flag_z}, '0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) bc++;
        end
        chk("no_done_after_reset", bc, 0);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk); #1;
            start      = ($urandom_range(0, 3) != 0);
            a          = $urandom;
            b          = $urandom >> $urandom_range(0, 31);
            acc        = $urandom;
            accumulate = 1'($urandom);
            tag_in     = 4'($urandom);
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
